// File: rtl/jtframe_joyser_tx.sv
// rtl/jtframe_joyser_tx.sv - debounced 74165-style serial joystick responder
module jtframe_joyser_tx #(
  parameter int   NBITS = 24,
  parameter int   DEBW  = 4,
  parameter logic FILL  = 1'b1
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [NBITS-1:0] btn_n,
  input  logic             JOY_CLK,
  input  logic             JOY_LOAD,
  output logic             JOY_DATA,
  output logic [7:0]       frame_cnt,
  output logic             overrun,
  output logic             short_frame
);

  // bit_cnt must hold 0..NBITS+1
  localparam int CW = $clog2(NBITS + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(NBITS);
  localparam logic [CW-1:0] CNT_OVR  = CW'(NBITS + 1);
  localparam logic [DEBW-1:0] DEB_MAX = {DEBW{1'b1}};

  logic                        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic                        load_s1_q, load_s1_d, load_s2_q, load_s2_d;
  logic [NBITS-1:0]            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [NBITS-1:0]            deb_q, deb_d;
  logic [NBITS-1:0][DEBW-1:0]  cnt_q, cnt_d;
  logic [NBITS-1:0]            sr_q, sr_d;
  logic [CW-1:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]                  frame_cnt_q, frame_cnt_d;
  logic                        overrun_q, overrun_d;
  logic                        short_q, short_d;
  logic                        clk_rise, load_act;

  // Two-stage synchronisers plus the previous-level register for edge detection
  always_comb begin
    clk_s1_d   = JOY_CLK;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    load_s1_d  = JOY_LOAD;
    load_s2_d  = load_s1_q;
    btn_s1_d   = btn_n;
    btn_s2_d   = btn_s1_q;
  end

  assign clk_rise = clk_s2_q & ~clk_prev_q;
  assign load_act = ~load_s2_q;

  // Per-bit debounce: a differing input must persist until the counter is full
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NBITS; i++) begin
      if (btn_s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_MAX) begin
        deb_d[i] = btn_s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEBW'(1);
      end
    end
  end

  // Shift chain: load beats clock; load is transparent to the debounced vector
  always_comb begin
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = 1'b0;
    short_d     = 1'b0;
    if (load_act) begin
      sr_d      = deb_d;
      bit_cnt_d = '0;
      if (bit_cnt_q != '0 && bit_cnt_q < CNT_DONE) short_d = 1'b1;
    end else if (clk_rise) begin
      sr_d = {sr_q[NBITS-2:0], FILL};
      if (bit_cnt_q != CNT_OVR)  bit_cnt_d   = bit_cnt_q + CW'(1);
      if (bit_cnt_q == CNT_LAST) frame_cnt_d = frame_cnt_q + 8'd1;
      if (bit_cnt_q >= CNT_DONE) overrun_d   = 1'b1;
    end
  end

  // State registers; synchronisers reset high so reset never produces an edge
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      load_s1_q   <= 1'b1;
      load_s2_q   <= 1'b1;
      btn_s1_q    <= '1;
      btn_s2_q    <= '1;
      deb_q       <= '1;
      cnt_q       <= '0;
      sr_q        <= '1;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_prev_q  <= clk_prev_d;
      load_s1_q   <= load_s1_d;
      load_s2_q   <= load_s2_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      short_q     <= short_d;
    end
  end

  assign JOY_DATA    = sr_q[NBITS-1];
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_jtframe_joyser_tx.sv
// tb/tb_jtframe_joyser_tx.sv - self-checking bench for jtframe_joyser_tx
module tb_jtframe_joyser_tx;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [23:0] btn_n;
  logic        JOY_CLK, JOY_LOAD;
  logic        JOY_DATA;
  logic [7:0]  frame_cnt;
  logic        overrun, short_frame;

  jtframe_joyser_tx #(.NBITS(24), .DEBW(4), .FILL(1'b1)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .btn_n       (btn_n),
    .JOY_CLK     (JOY_CLK),
    .JOY_LOAD    (JOY_LOAD),
    .JOY_DATA    (JOY_DATA),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .short_frame (short_frame)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov_seen = 0;
  int sf_seen = 0;
  int sf_cyc = 0;
  int fc_exp = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (overrun === 1'b1) ov_seen++;
    if (short_frame === 1'b1) begin
      sf_seen++;
      sf_cyc = cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] btn;
    int          nclk;
    int          frame_inc;
    int          ov;
    int          sf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_load(input int lo_w, input int hi_w);
    JOY_LOAD = 1'b0;
    step(lo_w);
    JOY_LOAD = 1'b1;
    step(hi_w);
  endtask

  task automatic pulse(input int hi, input int lo);
    JOY_CLK = 1'b1;
    step(hi);
    JOY_CLK = 1'b0;
    step(lo);
  endtask

  // Reference: the first n serial bits are the button word MSB-first, then FILL ones
  function automatic logic [31:0] model_word(input logic [23:0] b, input int n);
    logic [31:0] full;
    full = {b, 8'hFF};
    if (n == 0) return 32'h0;
    return full >> (32 - n);
  endfunction

  task automatic capture(input int n, input int hi, input int lo, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap = {cap[30:0], JOY_DATA};
      pulse(hi, lo);
    end
  endtask

  task automatic run_row(input string tag, input logic [23:0] b, input int n,
                         input int hi, input int lo,
                         input int e_fr, input int e_ov, input int e_sf);
    logic [31:0] cap;
    int ov0, sf0;
    btn_n = b;
    step(24);
    do_load(4, 4);
    ov0 = ov_seen;
    sf0 = sf_seen;
    capture(n, hi, lo, cap);
    chk({tag, "_bits"}, cap, model_word(b, n));
    fc_exp = (fc_exp + e_fr) % 256;
    chk({tag, "_frame_cnt"}, {24'h0, frame_cnt}, fc_exp);
    do_load(4, 4);
    chk({tag, "_overrun"}, ov_seen - ov0, e_ov);
    chk({tag, "_short"}, sf_seen - sf0, e_sf);
    chk({tag, "_reload_msb"}, {31'h0, JOY_DATA}, {31'h0, b[23]});
  endtask

  initial begin
    vec_t vecs[8];
    logic [31:0] cap;
    logic [23:0] rb;
    int n, sf0, c0, k;
    logic glitch_low;

    vecs[0] = '{24'hA5F00F, 24, 1, 0, 0};
    vecs[1] = '{24'hA5F00F, 26, 1, 2, 0};
    vecs[2] = '{24'h123456, 10, 0, 0, 1};
    vecs[3] = '{24'hFFFFFF,  0, 0, 0, 0};
    vecs[4] = '{24'h000000, 24, 1, 0, 0};
    vecs[5] = '{24'h800001, 25, 1, 1, 0};
    vecs[6] = '{24'h5A5A5A, 23, 0, 0, 1};
    vecs[7] = '{24'h0F0F0F,  1, 0, 0, 1};

    rst = 1'b1;
    btn_n = '1;
    JOY_CLK = 1'b0;
    JOY_LOAD = 1'b1;
    step(3);
    chk("rst_data", {31'h0, JOY_DATA}, 32'h1);
    chk("rst_frame_cnt", {24'h0, frame_cnt}, 32'h0);
    chk("rst_pulses", {30'h0, overrun, short_frame}, 32'h0);
    rst = 1'b0;
    step(2);

    // Table-driven frames
    for (int i = 0; i < 8; i++)
      run_row($sformatf("vec%0d", i), vecs[i].btn, vecs[i].nclk, 4, 4,
              vecs[i].frame_inc, vecs[i].ov, vecs[i].sf);

    // Randomised frames against the model
    for (int i = 0; i < 12; i++) begin
      rb = 24'($urandom);
      n  = $urandom_range(0, 27);
      run_row($sformatf("rnd%0d", i), rb, n, $urandom_range(3, 6), $urandom_range(3, 6),
              (n >= 24) ? 1 : 0, (n > 24) ? n - 24 : 0, (n >= 1 && n <= 23) ? 1 : 0);
    end

    // Short-frame pulse timing relative to the load falling edge
    btn_n = 24'h6B19E2;
    step(24);
    do_load(4, 4);
    for (int i = 0; i < 10; i++) pulse(4, 4);
    sf0 = sf_seen;
    c0 = cyc;
    do_load(4, 4);
    chk("short_count", sf_seen - sf0, 1);
    chk("short_latency", sf_cyc - c0, 3);
    chk("short_frame_cnt", {24'h0, frame_cnt}, fc_exp);
    chk("short_msb", {31'h0, JOY_DATA}, {31'h0, btn_n[23]});

    // Debounce: short glitch rejected, stable change accepted after 18 edges
    btn_n = '1;
    step(24);
    JOY_LOAD = 1'b0;
    step(4);
    chk("deb_idle", {31'h0, JOY_DATA}, 32'h1);
    glitch_low = 1'b0;
    btn_n[23] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (JOY_DATA === 1'b0) glitch_low = 1'b1;
    end
    btn_n[23] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (JOY_DATA === 1'b0) glitch_low = 1'b1;
    end
    chk("deb_glitch", {31'h0, glitch_low}, 32'h0);
    btn_n[23] = 1'b0;
    k = -1;
    for (int i = 1; i <= 40 && k < 0; i++) begin
      step(1);
      if (JOY_DATA === 1'b0) k = i;
    end
    chk("deb_latency", k, 18);
    JOY_LOAD = 1'b1;
    step(4);

    // Load priority: clock during load and clock coinciding with load
    btn_n = 24'h3C96A1;
    step(24);
    do_load(4, 4);
    for (int i = 0; i < 5; i++) pulse(4, 4);
    sf0 = sf_seen;
    JOY_LOAD = 1'b0;
    JOY_CLK = 1'b1;
    step(4);
    JOY_CLK = 1'b0;
    step(4);
    JOY_CLK = 1'b1;
    step(4);
    JOY_CLK = 1'b0;
    step(4);
    JOY_LOAD = 1'b1;
    step(4);
    chk("prio_short", sf_seen - sf0, 1);
    chk("prio_msb", {31'h0, JOY_DATA}, {31'h0, btn_n[23]});
    chk("prio_frame_cnt", {24'h0, frame_cnt}, fc_exp);
    capture(24, 4, 4, cap);
    chk("prio_bits", cap, model_word(btn_n, 24));
    fc_exp = (fc_exp + 1) % 256;
    chk("prio_frame_after", {24'h0, frame_cnt}, fc_exp);

    // Reset in the middle of a frame
    btn_n = 24'hA5F00F;
    step(24);
    do_load(4, 4);
    for (int i = 0; i < 12; i++) pulse(4, 4);
    rst = 1'b1;
    #1;
    chk("midrst_data", {31'h0, JOY_DATA}, 32'h1);
    chk("midrst_frame_cnt", {24'h0, frame_cnt}, 32'h0);
    step(2);
    rst = 1'b0;
    fc_exp = 0;
    step(24);
    chk("midrst_all_ones", {31'h0, JOY_DATA}, 32'h1);
    sf0 = sf_seen;
    do_load(4, 4);
    chk("midrst_no_short", sf_seen - sf0, 0);
    chk("midrst_msb", {31'h0, JOY_DATA}, 32'h1);
    capture(24, 4, 4, cap);
    chk("midrst_bits", cap, model_word(24'hA5F00F, 24));
    fc_exp = 1;

    // frame_cnt wrap after 256 complete frames from reset
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    fc_exp = 0;
    step(4);
    for (int f = 0; f < 255; f++) begin
      do_load(3, 3);
      for (int i = 0; i < 24; i++) pulse(3, 3);
    end
    chk("wrap_255", {24'h0, frame_cnt}, 32'd255);
    do_load(3, 3);
    for (int i = 0; i < 24; i++) pulse(3, 3);
    chk("wrap_0", {24'h0, frame_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
